// File: rtl/solve_sequencer.sv
// Run controller for the two-lane (row/column) parallel line solver.
// Starts a solve on a fresh rising edge of parse_done_i and counts completed line passes into sweeps.
// A run ends on abort, solver victory, cycle-budget timeout, or a stall (no new known cells over
// consecutive sweeps). The terminal result is reported once and held until the next run clears it.
//
// Ports
//   clk               clock
//   rst_n             asynchronous reset, active-low
//   parse_done_i      level: board parsed and option FIFOs loaded
//   abort_i           level: terminate the current run
//   num_rows_i        active rows
//   num_cols_i        active cols
//   line_done_r_i     1-cycle pulse: row lane finished one line write
//   line_done_c_i     1-cycle pulse: column lane finished one line write
//   solver_solved_i   solver victory flag
//   known_i           solver known-cell map, row-major (bit r*MAX_COLS+c)
//   solver_clr_o      1-cycle pulse: synchronous clear to the solver
//   solver_start_o    1-cycle pulse: solver started
//   busy_o            high while clearing, starting or running
//   done_o            run finished, result_o valid
//   result_o          00 aborted, 01 solved, 10 stalled, 11 timeout
//   sweeps_o          completed sweeps of current/last run, saturating at 255
module solve_sequencer #(
  parameter int unsigned MAX_ROWS     = 11,
  parameter int unsigned MAX_COLS     = 11,
  parameter int unsigned STALL_SWEEPS = 2,
  parameter int unsigned MAX_CYCLES   = 65535
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         parse_done_i,
  input  logic                         abort_i,
  input  logic [$clog2(MAX_ROWS)-1:0]  num_rows_i,
  input  logic [$clog2(MAX_COLS)-1:0]  num_cols_i,
  input  logic                         line_done_r_i,
  input  logic                         line_done_c_i,
  input  logic                         solver_solved_i,
  input  logic [MAX_ROWS*MAX_COLS-1:0] known_i,
  output logic                         solver_clr_o,
  output logic                         solver_start_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [1:0]                   result_o,
  output logic [7:0]                   sweeps_o
);

  localparam int unsigned LineW  = $clog2(MAX_ROWS + MAX_COLS) + 1;
  localparam int unsigned PopW   = $clog2(MAX_ROWS * MAX_COLS + 1);
  localparam int unsigned CycW   = $clog2(MAX_CYCLES + 1);
  localparam int unsigned StallW = $clog2(STALL_SWEEPS + 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StStart = 3'd2;
  localparam logic [2:0] StRun   = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  localparam logic [1:0] ResAbort   = 2'b00;
  localparam logic [1:0] ResSolved  = 2'b01;
  localparam logic [1:0] ResStalled = 2'b10;
  localparam logic [1:0] ResTimeout = 2'b11;

  logic [2:0]        state_q, state_d;
  logic              pd_q;
  logic              armed_q;
  logic              rise_q;
  logic              done_q, done_d;
  logic [1:0]        result_q, result_d;
  logic [7:0]        sweeps_q, sweeps_d;
  logic [LineW-1:0]  line_q, line_d;
  logic [StallW-1:0] stall_q, stall_d;
  logic [CycW-1:0]   cycle_q, cycle_d;
  logic [PopW-1:0]   prev_pop_q, prev_pop_d;

  logic [PopW-1:0]   pop;
  logic [LineW-1:0]  line_sum;
  logic [LineW-1:0]  line_nxt;
  logic              sweep_end;
  logic [StallW:0]   stall_inc;
  logic              stall_hit;

  // Popcount of the known map restricted to the active num_rows x num_cols window.
  always_comb begin
    pop = '0;
    for (int unsigned r = 0; r < MAX_ROWS; r++) begin
      for (int unsigned c = 0; c < MAX_COLS; c++) begin
        if ((r < 32'(num_rows_i)) && (c < 32'(num_cols_i))) begin
          pop = pop + PopW'(known_i[r*MAX_COLS + c]);
        end
      end
    end
  end

  always_comb begin
    line_sum  = LineW'(num_rows_i) + LineW'(num_cols_i);
    line_nxt  = line_q + LineW'(line_done_r_i) + LineW'(line_done_c_i);
    sweep_end = (line_nxt >= line_sum);
    stall_inc = {1'b0, stall_q} + 1'b1;
    stall_hit = (pop == prev_pop_q) && (stall_inc >= (StallW + 1)'(STALL_SWEEPS));
  end

  always_comb begin
    state_d    = state_q;
    done_d     = done_q;
    result_d   = result_q;
    sweeps_d   = sweeps_q;
    line_d     = line_q;
    stall_d    = stall_q;
    cycle_d    = cycle_q;
    prev_pop_d = prev_pop_q;

    case (state_q)
      StIdle: begin
        if (rise_q) state_d = StClear;
      end

      StClear: begin
        done_d     = 1'b0;
        result_d   = ResAbort;
        sweeps_d   = '0;
        line_d     = '0;
        stall_d    = '0;
        cycle_d    = '0;
        prev_pop_d = '0;
        if (abort_i) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (abort_i) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = ResAbort;
        end else begin
          state_d = StRun;
        end
      end

      StRun: begin
        cycle_d = cycle_q + 1'b1;
        line_d  = line_nxt;
        // Excess lines past the sweep boundary carry into the next sweep.
        if (sweep_end) begin
          line_d     = line_nxt - line_sum;
          prev_pop_d = pop;
          stall_d    = (pop == prev_pop_q) ? stall_inc[StallW-1:0] : '0;
          if (sweeps_q != 8'hff) sweeps_d = sweeps_q + 8'd1;
        end

        if (abort_i) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = ResAbort;
        end else if (solver_solved_i) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = ResSolved;
        end else if (cycle_q == CycW'(MAX_CYCLES - 1)) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = ResTimeout;
        end else if (sweep_end && stall_hit) begin
          state_d  = StDone;
          done_d   = 1'b1;
          result_d = ResStalled;
        end
      end

      StDone: begin
        if (!parse_done_i) state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pd_q       <= 1'b0;
      armed_q    <= 1'b0;
      rise_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= ResAbort;
      sweeps_q   <= '0;
      line_q     <= '0;
      stall_q    <= '0;
      cycle_q    <= '0;
      prev_pop_q <= '0;
    end else begin
      pd_q       <= parse_done_i;
      // A level held high across reset must not look like an edge: arm only after a low sample.
      armed_q    <= armed_q | ~parse_done_i;
      rise_q     <= parse_done_i & ~pd_q & armed_q;
      state_q    <= state_d;
      done_q     <= done_d;
      result_q   <= result_d;
      sweeps_q   <= sweeps_d;
      line_q     <= line_d;
      stall_q    <= stall_d;
      cycle_q    <= cycle_d;
      prev_pop_q <= prev_pop_d;
    end
  end

  always_comb begin
    solver_clr_o   = (state_q == StClear);
    solver_start_o = (state_q == StStart);
    busy_o         = (state_q == StClear) || (state_q == StStart) || (state_q == StRun);
    done_o         = done_q;
    result_o       = result_q;
    sweeps_o       = sweeps_q;
  end

endmodule

// File: tb/tb_solve_sequencer.sv
// Self-checking bench for solve_sequencer: a phase-level reference model compared against the DUT
// on every falling clock edge, plus directed scenarios with hand-computed literal expectations.
module tb_solve_sequencer;

  localparam int unsigned MR    = 11;
  localparam int unsigned MC    = 11;
  localparam int unsigned STALL = 2;
  localparam int unsigned MAXC  = 100;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           parse_done = 1'b0;
  logic           abort = 1'b0;
  logic [3:0]     nr = 4'd0;
  logic [3:0]     nc = 4'd0;
  logic           ldr = 1'b0;
  logic           ldc = 1'b0;
  logic           solved = 1'b0;
  logic [MR*MC-1:0] known = '0;
  logic           clr, start, busy, done;
  logic [1:0]     result;
  logic [7:0]     sweeps;

  int n_cmp = 0;
  int n_fail = 0;
  int clr_cnt = 0;
  int start_cnt = 0;

  solve_sequencer #(
    .MAX_ROWS    (MR),
    .MAX_COLS    (MC),
    .STALL_SWEEPS(STALL),
    .MAX_CYCLES  (MAXC)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .parse_done_i   (parse_done),
    .abort_i        (abort),
    .num_rows_i     (nr),
    .num_cols_i     (nc),
    .line_done_r_i  (ldr),
    .line_done_c_i  (ldc),
    .solver_solved_i(solved),
    .known_i        (known),
    .solver_clr_o   (clr),
    .solver_start_o (start),
    .busy_o         (busy),
    .done_o         (done),
    .result_o       (result),
    .sweeps_o       (sweeps)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {MIdle, MClear, MStart, MRun, MDone} mphase_e;
  mphase_e m_ph = MIdle;
  bit m_prev_pd = 1'b0;
  bit m_seen_low = 1'b0;
  bit m_trig = 1'b0;
  int m_done = 0;
  int m_res = 0;
  int m_sw = 0;
  int m_lines = 0;
  int m_runt = 0;
  int m_pops[$];

  function automatic int board_pop();
    int n = 0;
    for (int r = 0; r < int'(nr); r++)
      for (int c = 0; c < int'(nc); c++)
        if (known[r*MC + c]) n++;
    return n;
  endfunction

  // Stalled when the last STALL+1 sweep popcounts (starting from the implicit 0) are all equal.
  function automatic bit stalled_now();
    int last;
    if (m_pops.size() < STALL + 1) return 1'b0;
    last = m_pops[m_pops.size()-1];
    for (int i = 1; i <= STALL; i++)
      if (m_pops[m_pops.size()-1-i] != last) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit trig_next;
    bit new_sweep;
    int lsum;
    if (!rst_n) begin
      m_ph = MIdle; m_prev_pd = 0; m_seen_low = 0; m_trig = 0;
      m_done = 0; m_res = 0; m_sw = 0; m_lines = 0; m_runt = 0;
      m_pops.delete();
    end else begin
      trig_next = parse_done && !m_prev_pd && m_seen_low;
      case (m_ph)
        MIdle: if (m_trig) m_ph = MClear;
        MClear: begin
          m_done = 0; m_res = 0; m_sw = 0; m_lines = 0; m_runt = 0;
          m_pops.delete(); m_pops.push_back(0);
          if (abort) begin m_ph = MDone; m_done = 1; m_res = 0; end
          else m_ph = MStart;
        end
        MStart: begin
          if (abort) begin m_ph = MDone; m_done = 1; m_res = 0; end
          else m_ph = MRun;
        end
        MRun: begin
          lsum = int'(nr) + int'(nc);
          m_runt++;
          m_lines += int'(ldr) + int'(ldc);
          new_sweep = (m_lines / lsum) > m_sw;
          if (new_sweep) begin
            m_sw++;
            m_pops.push_back(board_pop());
          end
          if (abort)                          begin m_ph = MDone; m_done = 1; m_res = 0; end
          else if (solved)                    begin m_ph = MDone; m_done = 1; m_res = 1; end
          else if (m_runt == int'(MAXC))      begin m_ph = MDone; m_done = 1; m_res = 3; end
          else if (new_sweep && stalled_now()) begin m_ph = MDone; m_done = 1; m_res = 2; end
        end
        MDone: if (!parse_done) m_ph = MIdle;
        default: m_ph = MIdle;
      endcase
      m_trig = trig_next;
      m_prev_pd = parse_done;
      if (!parse_done) m_seen_low = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("clr",    int'(clr),    int'(m_ph == MClear));
    check("start",  int'(start),  int'(m_ph == MStart));
    check("busy",   int'(busy),   int'(m_ph == MClear || m_ph == MStart || m_ph == MRun));
    check("done",   int'(done),   m_done);
    check("result", int'(result), m_res);
    check("sweeps", int'(sweeps), (m_sw > 255) ? 255 : m_sw);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (clr === 1'b1) clr_cnt++;
    if (start === 1'b1) start_cnt++;
  endtask

  // First n cells of a board with 'cols' active columns, row-major.
  function automatic logic [MR*MC-1:0] cells(input int n, input int cols);
    logic [MR*MC-1:0] v = '0;
    for (int i = 0; i < n; i++) v[(i / cols) * MC + (i % cols)] = 1'b1;
    return v;
  endfunction

  // Ends in the START cycle.
  task automatic launch(input int rows, input int cols);
    nr = 4'(rows);
    nc = 4'(cols);
    parse_done = 1'b0;
    tick();
    tick();
    clr_cnt = 0;
    start_cnt = 0;
    parse_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (start === 1'b1) break;
      tick();
    end
    check("launch_start", int'(start), 1);
  endtask

  task automatic end_run();
    parse_done = 1'b0; abort = 1'b0; solved = 1'b0; ldr = 1'b0; ldc = 1'b0;
    tick(); tick(); tick();
    known = '0;
    check("end_idle_busy", int'(busy), 0);
  endtask

  initial begin
    int pulses;
    int exp_sw[5];
    exp_sw = '{0, 0, 1, 1, 2};

    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_result", int'(result), 0);
    check("rst_sweeps", int'(sweeps), 0);
    check("rst_clr",    int'(clr),    0);
    check("rst_start",  int'(start),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(); tick();

    // 1: solved at RUN cycle 20
    launch(3, 3);
    repeat (20) tick();
    check("t1_running", int'(busy), 1);
    solved = 1'b1;
    tick();
    solved = 1'b0;
    check("t1_done",   int'(done),   1);
    check("t1_result", int'(result), 1);
    repeat (5) tick();
    check("t1_clr_once",   clr_cnt,   1);
    check("t1_start_once", start_cnt, 1);
    end_run();
    check("t1_hold_done",   int'(done),   1);
    check("t1_hold_result", int'(result), 1);

    // 2: frozen popcount -> stalled after sweep 3
    launch(3, 3);
    known = cells(0, 3);
    known[0] = 1'b1; known[1] = 1'b1; known[12] = 1'b1; known[24] = 1'b1;
    known[8] = 1'b1; known[60] = 1'b1;
    tick();
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      ldr = k[0];
      ldc = ~k[0];
      tick();
      pulses++;
      if (done === 1'b1) break;
    end
    ldr = 1'b0; ldc = 1'b0;
    check("t2_pulses", pulses, 18);
    check("t2_done",   int'(done),   1);
    check("t2_result", int'(result), 2);
    check("t2_sweeps", int'(sweeps), 3);
    end_run();

    // 3: timeout at exactly RUN cycle 100, known grows every sweep
    launch(5, 5);
    tick();
    for (int k = 1; k <= 100; k++) begin
      known = cells(k / 5, 5);
      known[5] = k[0];
      known[79] = ~k[0];
      ldr = 1'b1; ldc = 1'b1;
      tick();
      if (k == 99) check("t3_not_yet", int'(done), 0);
    end
    ldr = 1'b0; ldc = 1'b0;
    check("t3_done",   int'(done),   1);
    check("t3_result", int'(result), 3);
    check("t3_sweeps", int'(sweeps), 20);
    end_run();

    // 4: paired pulses, 2x3 board; then 5a: abort and solved together
    launch(2, 3);
    tick();
    for (int p = 1; p <= 5; p++) begin
      known = cells(p, 3);
      ldr = 1'b1; ldc = 1'b1;
      tick();
      ldr = 1'b0; ldc = 1'b0;
      check($sformatf("t4_sweeps_pair%0d", p), int'(sweeps), exp_sw[p-1]);
      tick();
    end
    check("t4_still_running", int'(busy), 1);
    abort = 1'b1; solved = 1'b1;
    tick();
    abort = 1'b0; solved = 1'b0;
    check("t5a_done",   int'(done),   1);
    check("t5a_result", int'(result), 0);
    end_run();

    // 5b: abort during START
    launch(3, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5b_done",   int'(done),   1);
    check("t5b_result", int'(result), 0);
    check("t5b_busy",   int'(busy),   0);
    repeat (5) tick();
    check("t5b_clr_cnt",   clr_cnt,   1);
    check("t5b_start_cnt", start_cnt, 1);
    end_run();

    // 5c: abort during CLEAR
    nr = 4'd3; nc = 4'd3;
    parse_done = 1'b0;
    tick(); tick();
    clr_cnt = 0; start_cnt = 0;
    parse_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (clr === 1'b1) break;
      tick();
    end
    check("t5c_clr_seen", int'(clr), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5c_done",   int'(done),   1);
    check("t5c_result", int'(result), 0);
    repeat (4) tick();
    check("t5c_start_cnt", start_cnt, 0);
    check("t5c_clr_cnt",   clr_cnt,   1);
    end_run();

    // 6: async reset mid-RUN, level held high afterwards, then edge latency
    launch(3, 3);
    tick();
    for (int k = 1; k <= 8; k++) begin
      known = cells(k, 3);
      ldr = 1'b1;
      tick();
    end
    ldr = 1'b0;
    check("t6_sweeps_pre", int'(sweeps), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_busy",   int'(busy),   0);
    check("t6_rst_sweeps", int'(sweeps), 0);
    check("t6_rst_done",   int'(done),   0);
    check("t6_rst_clr",    int'(clr),    0);
    check("t6_rst_start",  int'(start),  0);
    check("t6_rst_result", int'(result), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clr_cnt = 0; start_cnt = 0;
    repeat (10) tick();
    check("t6_no_retrigger", clr_cnt, 0);
    check("t6_idle_busy",    int'(busy), 0);
    parse_done = 1'b0;
    tick(); tick();
    parse_done = 1'b1;
    tick();
    check("t6_lat1_clr", int'(clr), 0);
    tick();
    check("t6_lat2_clr",  int'(clr),  1);
    check("t6_lat2_busy", int'(busy), 1);
    tick();
    check("t6_lat3_start", int'(start), 1);
    tick();
    solved = 1'b1;
    tick();
    solved = 1'b0;
    check("t6_result", int'(result), 1);
    end_run();

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
